// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch and data access.
// Optional macro ARB_ROUND_ROBIN_EN: on a collision, grant the requester not granted last.

module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 15,
    parameter int CW      = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic [DW-1:0] if_rdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_ack,
    output logic [DW-1:0] dm_rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic          sel,
    output logic          stall_if,
    output logic          err
);

    // Handshake: each requester holds req until its one-cycle ack; the memory
    // side holds mem_req with stable address/data until mem_ready completes it.

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

    state_t        state, state_d;
    logic          mem_req_d, mem_we_d, sel_d, err_d;
    logic          if_ack_d, dm_ack_d;
    logic [AW-1:0] mem_addr_d;
    logic [DW-1:0] mem_wdata_d, if_rdata_d, dm_rdata_d;
    logic [CW-1:0] wait_cnt, wait_cnt_d;
    logic          grant_dm;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant, last_grant_d;   // 0=IF, 1=DM
    assign grant_dm = dm_req & (~if_req | ~last_grant);
`else
    assign grant_dm = dm_req;
`endif

    assign stall_if = if_req & ~if_ack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            sel       <= 1'b0;
            err       <= 1'b0;
            if_ack    <= 1'b0;
            dm_ack    <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            wait_cnt  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant <= 1'b0;
`endif
        end else begin
            state     <= state_d;
            mem_req   <= mem_req_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            sel       <= sel_d;
            err       <= err_d;
            if_ack    <= if_ack_d;
            dm_ack    <= dm_ack_d;
            if_rdata  <= if_rdata_d;
            dm_rdata  <= dm_rdata_d;
            wait_cnt  <= wait_cnt_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant <= last_grant_d;
`endif
        end
    end

    always_comb begin
        state_d     = state;
        mem_req_d   = mem_req;
        mem_we_d    = mem_we;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        sel_d       = sel;
        err_d       = err;
        if_ack_d    = if_ack;
        dm_ack_d    = dm_ack;
        if_rdata_d  = if_rdata;
        dm_rdata_d  = dm_rdata;
        wait_cnt_d  = wait_cnt;
`ifdef ARB_ROUND_ROBIN_EN
        last_grant_d = last_grant;
`endif

        case (state)
            IDLE: begin
                if (if_req || dm_req) begin
                    state_d    = BUSY;
                    mem_req_d  = 1'b1;
                    sel_d      = grant_dm;
                    wait_cnt_d = '0;
`ifdef ARB_ROUND_ROBIN_EN
                    last_grant_d = grant_dm;
`endif
                    if (grant_dm) begin
                        mem_we_d    = dm_we;
                        mem_addr_d  = dm_addr;
                        mem_wdata_d = dm_wdata;
                    end else begin
                        mem_we_d    = 1'b0;
                        mem_addr_d  = if_addr;
                        mem_wdata_d = '0;
                    end
                end
            end

            BUSY: begin
                if (mem_ready) begin
                    state_d   = DONE;
                    mem_req_d = 1'b0;
                    if (sel) begin
                        dm_ack_d   = 1'b1;
                        dm_rdata_d = mem_we ? '0 : mem_rdata;
                    end else begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = mem_rdata;
                    end
                end else if (wait_cnt == WAIT_LAST) begin
                    // Hung memory: complete the access with zero data and flag it.
                    state_d   = DONE;
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                    if (sel) begin
                        dm_ack_d   = 1'b1;
                        dm_rdata_d = '0;
                    end else begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = '0;
                    end
                end else begin
                    wait_cnt_d = wait_cnt + CW'(1);
                end
            end

            DONE: begin
                state_d  = IDLE;
                if_ack_d = 1'b0;
                dm_ack_d = 1'b0;
            end

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-ported memory between the instruction-fetch (IF) and data-memory (DM) stages of the pipelined CPU. Captures one request at a time and drives the memory-side handshake. Generates the registered select for the shared address/data 2:1 mux in the datapath, and a fetch-stall signal for the pipeline control. A watchdog converts a hung memory access into an error flag instead of a CPU deadlock.

Parameters:
AW, 32, address width in bits
DW, 32, data width in bits
TIMEOUT, 15, max BUSY cycles without mem_ready before abort (1..2^CW-1)
CW, 4, watchdog counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
if_req  in  1  fetch request, held until if_ack
if_addr  in  AW  fetch address
if_ack  out  1  one-cycle pulse: fetch complete, if_rdata valid
if_rdata  out  DW  fetched word
dm_req  in  1  data request, held until dm_ack
dm_we  in  1  1=store, 0=load
dm_addr  in  AW  data address
dm_wdata  in  DW  store data
dm_ack  out  1  one-cycle pulse: data access complete
dm_rdata  out  DW  load data (0 for stores)
mem_req  out  1  memory request, held until mem_ready
mem_we  out  1  memory write enable
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, valid with mem_ready
mem_ready  in  1  memory completion, sampled only while mem_req=1
sel  out  1  shared-mux select: 0=IF, 1=DM
stall_if  out  1  fetch stall to pipeline control
err  out  1  sticky watchdog error

Behaviour:
- Reset (async, rst=1): state IDLE; mem_req, mem_we, if_ack, dm_ack, sel, err = 0; mem_addr, mem_wdata, if_rdata, dm_rdata = 0; wait counter = 0; last-grant = IF.
- FSM states: IDLE, BUSY, DONE.
- IDLE, no request: stays IDLE; all outputs hold.
- IDLE with a request: arbitrates at the clock edge.
  - Default priority: DM over IF; DM is the older instruction.
  - Winner's addr/we/wdata are registered into mem_addr/mem_we/mem_wdata. IF grants force mem_we=0 and mem_wdata=0.
  - sel <= winner. mem_req <= 1. Go to BUSY. Wait counter cleared.
- BUSY: mem_req, mem_addr, mem_we, mem_wdata and sel are held stable. Counter increments each cycle mem_ready=0.
  - mem_ready=1: mem_req <= 0. Winner's rdata <= mem_rdata (loads and fetches) or 0 (stores). Winner's ack <= 1. Go to DONE.
  - mem_ready=0 with counter == TIMEOUT-1: abort. mem_req <= 0, err <= 1, winner's rdata <= 0, winner's ack <= 1, go to DONE.
- DONE: ack is high for exactly this cycle. No arbitration. Next state is IDLE with acks cleared. A requester drops req at the edge where it samples ack, so it is low in the following IDLE cycle.
- Minimum latency: request sampled at edge 0 -> mem_req high in cycle 1 -> with mem_ready in cycle 1, ack in cycle 2. Back-to-back grants are 3 cycles apart.
- sel keeps the last grant in IDLE. It changes only at a grant edge and never during BUSY/DONE.
- stall_if = if_req & ~if_ack (combinational). It covers both losing arbitration and waiting for memory.
- Requests that change addr/data while pending are undefined; inputs are sampled only at the grant edge.
- err stays set until rst. The arbiter keeps serving requests after an error.
- rst mid-BUSY aborts the transaction immediately: mem_req=0, no ack is generated, the requester re-issues.
- mem_ready while in IDLE or DONE is ignored.

Optional Feature:
Macro ARB_ROUND_ROBIN_EN.
- Defined: when if_req and dm_req are both high in IDLE, grant the requester not granted last. The last-grant register updates on every grant. A single requester is always granted.
- Undefined: fixed DM>IF priority; last-grant register absent.

Test Plan:
- Reset mid-BUSY: rst pulse asynchronously -> mem_req, sel, acks, err = 0 within the same cycle; FSM returns to IDLE.
- Fetch only: if_req=1, if_addr=0x00000040, mem_ready=1 in cycle 1 with mem_rdata=0x20080005 -> mem_addr=0x40, mem_we=0, sel=0, if_ack pulse in cycle 2, if_rdata=0x20080005, stall_if high cycles 0-1.
- Collision (macro off): if_req and dm_req rise together; dm store to 0x100 with wdata 0xDEADBEEF -> DM granted first (sel=1, mem_we=1), dm_ack with dm_rdata=0. IF is then granted 3 cycles later; stall_if stays high throughout.
- Collision (macro on): after a previous DM grant, both request -> IF granted first, then DM.
- Wait states: mem_ready delayed 5 cycles -> mem_req held 6 cycles, mem_addr stable, ack exactly 1 cycle after mem_ready, err=0.
- Timeout: mem_ready never asserted, TIMEOUT=15 -> mem_req drops after 15 BUSY cycles, err=1 sticky, ack pulses with rdata=0. The next request completes normally with err still 1.
